// File: rtl/kronos_wb.sv
// kronos_wb: RV32I write-back stage (commit, branch, load/store, traps); KRONOS_WB_MISALIGN_CHECK_EN traps misaligned accesses.
// execute = {result1[31:0], result2[31:0], rd[4:0], rd_write, branch, branch_cond, ld, ld_size[1:0], ld_sign, st, illegal}
module kronos_wb (
  input  logic        clk,
  input  logic        rstz,
  input  logic [77:0] execute,
  input  logic        pipe_in_vld,
  output logic        pipe_in_rdy,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en,
  output logic [31:0] branch_target,
  output logic        branch,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic [31:0] data_rd_data,
  input  logic        data_ack,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_value
);
  typedef enum logic {STEADY, MEM} state_t;
  state_t      r_state, w_state;
  logic [31:0] w_res1, w_res2, w_sh, w_ld_data;
  logic [4:0]  w_rd, r_rd;
  logic [1:0]  w_ld_size, w_off, r_size, r_off;
  logic        w_rd_write, w_branch, w_branch_cond, w_ld, w_ld_sign, w_st, w_illegal;
  logic        w_acc, w_mem, w_half, w_word, w_mis, w_rdok, w_br, w_go;
  logic        r_ld, r_wr, r_sign;
  logic [3:0]  w_mask;
  assign {w_res1, w_res2, w_rd, w_rd_write, w_branch, w_branch_cond, w_ld, w_ld_size, w_ld_sign, w_st, w_illegal} = execute;
  assign pipe_in_rdy = r_state == STEADY;
  assign w_acc  = pipe_in_vld & pipe_in_rdy;
  assign w_mem  = w_ld | w_st;
  assign w_half = w_ld_size == 2'd1;
  assign w_word = w_ld_size[1];
  // Half accesses use lane A[1] only; word accesses always use lane 0.
  assign w_off  = w_word ? 2'b00 : w_half ? {w_res1[1], 1'b0} : w_res1[1:0];
  assign w_mask = w_word ? 4'b1111 : w_half ? 4'b0011 << w_off : 4'b0001 << w_off;
`ifdef KRONOS_WB_MISALIGN_CHECK_EN
  assign w_mis  = (w_half & w_res1[0]) | (w_word & |w_res1[1:0]);
`else
  assign w_mis  = 1'b0;
`endif
  assign w_rdok = w_rd_write & |w_rd;
  assign w_br   = w_branch | (w_branch_cond & w_res1[0]);
  assign w_go   = w_acc & ~w_illegal & w_mem & ~w_mis;
  assign w_sh   = data_rd_data >> {r_off, 3'b000};
  assign w_ld_data = r_size[1] ? w_sh :
                     r_size == 2'd1 ? {{16{r_sign & w_sh[15]}}, w_sh[15:0]} :
                     {{24{r_sign & w_sh[7]}}, w_sh[7:0]};
  always_comb begin
    w_state = r_state;
    w_state = r_state == STEADY ? (w_go ? MEM : STEADY) : (data_ack ? STEADY : MEM);
  end
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_state       <= STEADY;
      regwr_data    <= '0;
      regwr_sel     <= '0;
      regwr_en      <= 1'b0;
      branch_target <= '0;
      branch        <= 1'b0;
      data_addr     <= '0;
      data_wr_data  <= '0;
      data_mask     <= '0;
      data_wr_en    <= 1'b0;
      data_req      <= 1'b0;
      trap          <= 1'b0;
      trap_cause    <= '0;
      trap_value    <= '0;
      r_ld          <= 1'b0;
      r_wr          <= 1'b0;
      r_rd          <= '0;
      r_size        <= '0;
      r_sign        <= 1'b0;
      r_off         <= '0;
    end else begin
      r_state  <= w_state;
      regwr_en <= 1'b0;
      branch   <= 1'b0;
      trap     <= 1'b0;
      if (w_acc) begin
        if (w_illegal | (w_mem & w_mis)) begin
          trap       <= 1'b1;
          trap_cause <= w_illegal ? 2'd0 : w_st ? 2'd2 : 2'd1;
          trap_value <= w_res1;
        end else if (w_mem) begin
          data_req     <= 1'b1;
          data_wr_en   <= w_st;
          data_addr    <= {w_res1[31:2], 2'b00};
          data_mask    <= w_st ? w_mask : 4'b1111;
          data_wr_data <= w_res2 << {w_off, 3'b000};
          r_ld         <= w_ld & ~w_st;
          r_wr         <= w_rdok;
          r_rd         <= w_rd;
          r_size       <= w_ld_size;
          r_sign       <= w_ld_sign;
          r_off        <= w_off;
        end else begin
          regwr_en <= w_rdok;
          branch   <= w_br;
          if (w_rdok) begin
            regwr_data <= w_res1;
            regwr_sel  <= w_rd;
          end
          if (w_br) branch_target <= w_res2;
        end
      end
      if (r_state == MEM && data_ack) begin
        data_req <= 1'b0;
        regwr_en <= r_ld & r_wr;
        if (r_ld & r_wr) begin
          regwr_data <= w_ld_data;
          regwr_sel  <= r_rd;
        end
      end
    end
  end
endmodule

// File: tb/tb_kronos_wb.sv
// tb_kronos_wb: directed bench for kronos_wb with a strobe scoreboard (regwr/branch/trap events).
module tb_kronos_wb;
  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic [77:0] execute = '0;
  logic        pipe_in_vld = 1'b0;
  logic        pipe_in_rdy;
  logic [31:0] regwr_data, branch_target, data_addr, data_wr_data, trap_value;
  logic [4:0]  regwr_sel;
  logic        regwr_en, branch, data_wr_en, data_req, trap;
  logic [3:0]  data_mask;
  logic [1:0]  trap_cause;
  logic [31:0] data_rd_data = '0;
  logic        data_ack = 1'b0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [1:0] kind; logic [4:0] a; logic [31:0] d;} ev_t;
  ev_t sb[$];

  kronos_wb dut (
    .clk(clk), .rstz(rstz), .execute(execute), .pipe_in_vld(pipe_in_vld), .pipe_in_rdy(pipe_in_rdy),
    .regwr_data(regwr_data), .regwr_sel(regwr_sel), .regwr_en(regwr_en),
    .branch_target(branch_target), .branch(branch),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask), .data_wr_en(data_wr_en),
    .data_req(data_req), .data_rd_data(data_rd_data), .data_ack(data_ack),
    .trap(trap), .trap_cause(trap_cause), .trap_value(trap_value)
  );

  always #5 clk = ~clk;

  function automatic logic [77:0] ex(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] rd,
                                     input logic rdw, input logic br, input logic brc, input logic ld,
                                     input logic [1:0] sz, input logic sg, input logic st, input logic il);
    return {r1, r2, rd, rdw, br, brc, ld, sz, sg, st, il};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d);
    sb.push_back({k, a, d});
  endtask

  task automatic pop_chk(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d, input string tag);
    ev_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s: observed unexpected strobe a=%0d d=%h, expected none", tag, a, d);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_kind"}, 32'(k), 32'(e.kind));
      chk({tag, "_sel"}, 32'(a), 32'(e.a));
      chk({tag, "_data"}, d, e.d);
    end
  endtask

  task automatic issue(input logic [77:0] x);
    chk("rdy_at_issue", 32'(pipe_in_rdy), 32'd1);
    execute = x;
    pipe_in_vld = 1'b1;
    @(posedge clk); #1;
    pipe_in_vld = 1'b0;
    execute = '0;
  endtask

  task automatic mem_txn(input logic [31:0] rdata, input int wait_cyc, input logic [31:0] addr,
                         input logic [3:0] mask, input logic we, input logic chk_wd, input logic [31:0] wdata);
    int n = 0;
    @(negedge clk);
    while (!data_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("req_raised", 32'(data_req), 32'd1);
    chk("req_latency", n, 0);
    chk("addr", data_addr, addr);
    chk("mask", 32'(data_mask), 32'(mask));
    chk("wr_en", 32'(data_wr_en), 32'(we));
    if (chk_wd) chk("wr_data", data_wr_data, wdata);
    chk("rdy_busy", 32'(pipe_in_rdy), 32'd0);
    repeat (wait_cyc) begin
      @(posedge clk); #1;
      chk("rdy_wait", 32'(pipe_in_rdy), 32'd0);
      chk("req_hold", 32'(data_req), 32'd1);
      chk("addr_stable", data_addr, addr);
    end
    data_ack = 1'b1;
    data_rd_data = rdata;
    @(posedge clk); #1;
    data_ack = 1'b0;
    data_rd_data = $urandom;
    @(negedge clk);
    chk("req_dropped", 32'(data_req), 32'd0);
    chk("rdy_after_ack", 32'(pipe_in_rdy), 32'd1);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (regwr_en) pop_chk(2'd0, regwr_sel, regwr_data, "regwr");
        if (branch) pop_chk(2'd1, 5'd0, branch_target, "branch");
        if (trap) pop_chk(2'd2, 5'(trap_cause), trap_value, "trap");
      end
      begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    #3;
    chk("rst_rdy", 32'(pipe_in_rdy), 32'd1);
    chk("rst_regwr_en", 32'(regwr_en), 32'd0);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr_en", 32'(data_wr_en), 32'd0);
    chk("rst_mask", 32'(data_mask), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_trap_cause", 32'(trap_cause), 32'd0);
    chk("rst_regwr_data", regwr_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rstz = 1'b1;

    push(2'd0, 5'd5, 32'hDEADBEEF);
    issue(ex(32'hDEADBEEF, 32'h0, 5'd5, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    issue(ex(32'h12345678, 32'h0, 5'd0, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    push(2'd0, 5'd31, 32'h0000_0A0A);
    issue(ex(32'h0000_0A0A, 32'h0, 5'd31, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    issue(ex(32'h5555_5555, 32'h0, 5'd6, 0, 0, 0, 0, 2'd0, 0, 0, 0));

    push(2'd1, 5'd0, 32'h100);
    issue(ex(32'h1, 32'h100, 5'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0));
    issue(ex(32'h0, 32'h100, 5'd0, 0, 0, 1, 0, 2'd0, 0, 0, 0));
    push(2'd0, 5'd1, 32'h44);
    push(2'd1, 5'd0, 32'h200);
    issue(ex(32'h44, 32'h200, 5'd1, 1, 1, 0, 0, 2'd0, 0, 0, 0));
    repeat (2) @(negedge clk);

    push(2'd0, 5'd7, 32'hFFFFFF80);
    issue(ex(32'h1003, 32'h0, 5'd7, 1, 0, 0, 1, 2'd0, 1, 0, 0));
    mem_txn(32'h80112233, 2, 32'h1000, 4'hF, 0, 0, 32'h0);
    push(2'd0, 5'd8, 32'h00000080);
    issue(ex(32'h1003, 32'h0, 5'd8, 1, 0, 0, 1, 2'd0, 0, 0, 0));
    mem_txn(32'h80112233, 2, 32'h1000, 4'hF, 0, 0, 32'h0);

    issue(ex(32'h2002, 32'h0000ABCD, 5'd3, 1, 0, 0, 0, 2'd1, 0, 1, 0));
    mem_txn(32'hFFFFFFFF, 1, 32'h2000, 4'b1100, 1, 1, 32'hABCD0000);
    issue(ex(32'h5001, 32'h000000EE, 5'd0, 0, 0, 0, 0, 2'd0, 0, 1, 0));
    mem_txn(32'h0, 0, 32'h5000, 4'b0010, 1, 1, 32'h0000EE00);

    push(2'd0, 5'd9, 32'h12345678);
    issue(ex(32'h4000, 32'h0, 5'd9, 1, 0, 0, 1, 2'd2, 1, 0, 0));
    mem_txn(32'h12345678, 0, 32'h4000, 4'hF, 0, 0, 32'h0);
    push(2'd0, 5'd10, 32'hFFFF8001);
    issue(ex(32'h4002, 32'h0, 5'd10, 1, 0, 0, 1, 2'd1, 1, 0, 0));
    mem_txn(32'h80010000, 1, 32'h4000, 4'hF, 0, 0, 32'h0);
    issue(ex(32'h4001, 32'h0, 5'd0, 1, 0, 0, 1, 2'd0, 1, 0, 0));
    mem_txn(32'h0000FF00, 0, 32'h4000, 4'hF, 0, 0, 32'h0);

    push(2'd2, 5'd0, 32'hBAD00001);
    issue(ex(32'hBAD00001, 32'h0, 5'd4, 1, 1, 0, 1, 2'd2, 0, 0, 1));
    chk("illegal_no_req", 32'(data_req), 32'd0);
    chk("illegal_trap", 32'(trap), 32'd1);
    push(2'd0, 5'd12, 32'hCAFE0000);
    issue(ex(32'hCAFE0000, 32'h0, 5'd12, 1, 0, 0, 0, 2'd0, 0, 0, 0));
    chk("after_trap_no_trap", 32'(trap), 32'd0);

`ifdef KRONOS_WB_MISALIGN_CHECK_EN
    push(2'd2, 5'd1, 32'h3001);
    issue(ex(32'h3001, 32'h0, 5'd13, 1, 0, 0, 1, 2'd2, 0, 0, 0));
    chk("mis_ld_no_req", 32'(data_req), 32'd0);
    chk("mis_ld_rdy", 32'(pipe_in_rdy), 32'd1);
    push(2'd2, 5'd2, 32'h3003);
    issue(ex(32'h3003, 32'h1234, 5'd0, 0, 0, 0, 0, 2'd1, 0, 1, 0));
    chk("mis_st_no_req", 32'(data_req), 32'd0);
`else
    push(2'd0, 5'd13, 32'h0000BEEF);
    issue(ex(32'h3003, 32'h0, 5'd13, 1, 0, 0, 1, 2'd1, 0, 0, 0));
    mem_txn(32'hBEEF0000, 0, 32'h3000, 4'hF, 0, 0, 32'h0);
    issue(ex(32'h3001, 32'h0000A5A5, 5'd0, 0, 0, 0, 0, 2'd1, 0, 1, 0));
    mem_txn(32'h0, 0, 32'h3000, 4'b0011, 1, 1, 32'h0000A5A5);
`endif

    issue(ex(32'h6000, 32'h0, 5'd14, 1, 0, 0, 1, 2'd2, 0, 0, 0));
    @(negedge clk);
    chk("rst_mid_req_up", 32'(data_req), 32'd1);
    #2 rstz = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(data_req), 32'd0);
    chk("rst_mid_rdy", 32'(pipe_in_rdy), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rstz = 1'b1;
    chk("rst_release_rdy", 32'(pipe_in_rdy), 32'd1);
    data_ack = 1'b1;
    data_rd_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    data_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray_ack_no_req", 32'(data_req), 32'd0);
    chk("stray_ack_rdy", 32'(pipe_in_rdy), 32'd1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
